v_multaddsub_arbiter: RTL and testbench
=======================================

# v_multaddsub_arbiter

Four-requester round-robin arbiter wrapped around a shared, pipelined multiply-add/subtract datapath (RES = C ± A*B, two register levels on the multiplier operands). Each cycle at most one requester's operand set enters the pipeline. The result exits with the winner's ID tag so downstream logic can route it. The block sits between several compute clients and a single DSP-style MAC resource, replacing per-client multipliers.

## Interface
- WIDTH, 8, operand width of A, B and C; result width is 2*WIDTH.
- clk  in  1  rising-edge clock; all registers use it.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester i; held high with operands stable until gnt[i] is seen.
- a_in  in  4*WIDTH  requester i operand A at bits [i*WIDTH +: WIDTH].
- b_in  in  4*WIDTH  requester i operand B, same packing.
- c_in  in  4*WIDTH  requester i operand C, same packing.
- add_sub  in  4  requester i: 1 = C + A*B, 0 = C − A*B.
- gnt  out  4  one-hot, one-cycle grant pulse; registered.
- res_valid  out  1  result strobe; one cycle per granted request.
- res_id  out  2  index of the requester owning res.
- res  out  2*WIDTH  result; registered.

## Operation
- Arbitration is combinational each cycle over eligible requests, where eligible = req & ~gnt. A requester whose gnt is high this cycle is masked, so its still-high req is not re-granted.
- Round-robin pointer ptr (2 bits): search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first eligible requester wins.
- On a clock edge with a winner w:
  - Stage 1 captures a_in/b_in/c_in/add_sub slice w, id = w, and v1 = 1.
  - gnt register becomes one-hot w.
  - ptr becomes w+1 mod 4.
- On a clock edge with no winner: v1 = 0, gnt = 0, ptr unchanged.
- Stage 2 copies stage 1 unconditionally (A, B, C, add_sub, id, v2 = v1). This is the second operand register level.
- Datapath from stage 2 is combinational: prod = A2*B2, unsigned, 2*WIDTH bits.
  - sum = C2 + prod when add_sub2 = 1, else C2 − prod.
  - C is zero-extended to 2*WIDTH. Result is truncated modulo 2^(2*WIDTH); no saturation, no carry or borrow output.
- Output register captures sum, id2 and v2 into res, res_id and res_valid every cycle.
- res and res_id hold their last value when res_valid = 0. Consumers must sample only on res_valid.
- No backpressure: results must be accepted the cycle they are presented.
- Reset (asynchronous assert, any time, including mid-operation):
  - gnt = 0, res_valid = 0, res = 0, res_id = 0, ptr = 0.
  - All stage valid bits and data registers = 0.
  - In-flight operations are discarded and produce no res_valid after reset release.

## Timing
- Request presented in cycle t and winning arbitration: gnt pulses in cycle t+1 and res_valid pulses in cycle t+3.
- Latency is 3 cycles from request to result and 2 cycles from gnt to res_valid.
- Throughput: one issue per cycle whenever two or more requesters are active.
- A single continuously-requesting client is granted every other cycle because of the gnt mask.
- Results leave in grant order. Each gnt maps to exactly one res_valid.
- A requester may change its operands or deassert req in the cycle its gnt is high.
- A request with no gnt yet must keep its operands stable; changing them is a protocol violation.
- After reset release, the first edge may already grant. ptr = 0 gives requester 0 first priority.

## Test plan
- Single request, WIDTH=8: req=0001, A=200, B=100, C=5, add_sub=1 → gnt=0001 at t+1; res_valid at t+3 with res=0x4E25 (20005), res_id=0.
- Subtract wrap: requester 2, A=200, B=100, C=5, add_sub=0 → res=0xB1E5 (45541), res_id=2.
- Add overflow: A=255, B=255, C=255, add_sub=1 → res=0xFF00 (65280); A=255, B=255, C=0, add_sub=0 → res=0x01FF (511, i.e. −65025 mod 2^16).
- All four requesters held high from reset release, each deasserting after its grant:
  - Grants must be 0001, 0010, 0100, 1000 on consecutive cycles.
  - res_id must be 0, 1, 2, 3 on consecutive cycles, each with its correct result.
- Requester 1 alone holds req high for 6 cycles → gnt[1] pulses on alternate cycles (3 grants), with matching res_valid pulses 2 cycles after each.
- Reset mid-flight: grant two requests, assert rst_n=0 asynchronously between clock edges before their results → all outputs 0 immediately; after release, no res_valid until a new request is granted, and ptr has restarted at 0.

Source files
------------

// File: rtl/v_multaddsub_arbiter.sv
// v_multaddsub_arbiter: four-way round-robin arbiter feeding a shared
// pipelined multiply-add/subtract unit (res = c +/- a*b).
// Each grant enters stage 1 and reaches the output register two edges later.
// The result carries the requester ID, so results leave in grant order.
module v_multaddsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  input  logic [4*WIDTH-1:0] c_in,
  input  logic [3:0]         add_sub,
  output logic [3:0]         gnt,
  output logic               res_valid,
  output logic [1:0]         res_id,
  output logic [2*WIDTH-1:0] res
);

  // One operand register level. It holds the operands, the operation and the owner tag.
  typedef struct packed {
    logic             v;
    logic [1:0]       id;
    logic             add_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } stage_t;

  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         gnt_q, gnt_d;
  stage_t             s1_q, s1_d;
  stage_t             s2_q, s2_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [1:0]         res_id_q, res_id_d;
  logic               res_valid_q, res_valid_d;

  logic [3:0]         eligible;
  logic               found;
  logic [1:0]         win;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] c_ext;
  logic [2*WIDTH-1:0] sum;

  // Round-robin search from ptr, skipping requesters that are being granted this cycle
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    eligible = req & ~gnt_q;
    found    = 1'b0;
    win      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && eligible[ptr_q + 2'(k)]) begin
        found = 1'b1;
        win   = ptr_q + 2'(k);
      end
    end
  end

  // Grant, pointer and stage-1 capture of the winner's operand slice
  always_comb begin
    gnt_d = 4'b0000;
    ptr_d = ptr_q;
    s1_d  = s1_q;
    s1_d.v = 1'b0;
    if (found) begin
      gnt_d         = 4'b0001 << win;
      ptr_d         = win + 2'd1;
      s1_d.v        = 1'b1;
      s1_d.id       = win;
      s1_d.add_sub  = add_sub[win];
      s1_d.a        = a_in[win*WIDTH +: WIDTH];
      s1_d.b        = b_in[win*WIDTH +: WIDTH];
      s1_d.c        = c_in[win*WIDTH +: WIDTH];
    end
  end

  // Stage 2 is a plain copy of stage 1. It is the second operand register level.
  always_comb begin
    s2_d = s1_q;
  end

  // Unsigned multiply, then add or subtract against zero-extended C, modulo 2^(2*WIDTH)
  always_comb begin
    prod  = {{WIDTH{1'b0}}, s2_q.a} * {{WIDTH{1'b0}}, s2_q.b};
    c_ext = {{WIDTH{1'b0}}, s2_q.c};
    sum   = s2_q.add_sub ? (c_ext + prod) : (c_ext - prod);
  end

  // Output register updates data only on valid, so res/res_id hold between strobes
  always_comb begin
    res_valid_d = s2_q.v;
    res_d       = res_q;
    res_id_d    = res_id_q;
    if (s2_q.v) begin
      res_d    = sum;
      res_id_d = s2_q.id;
    end
  end

  // State registers: all flops, including the pipeline data, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so res reads 0 out of reset and stale operands never leak.
      ptr_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      s1_q        <= '0;
      s2_q        <= '0;
      res_q       <= '0;
      res_id_q    <= 2'd0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values of the others.
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res       = res_q;

endmodule

// File: tb/tb_v_multaddsub_arbiter.sv
// Directed testbench for v_multaddsub_arbiter with hand-computed expected results.
module tb_v_multaddsub_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_in;
  logic [4*WIDTH-1:0] b_in;
  logic [4*WIDTH-1:0] c_in;
  logic [3:0]         add_sub;
  logic [3:0]         gnt;
  logic               res_valid;
  logic [1:0]         res_id;
  logic [2*WIDTH-1:0] res;

  int errors = 0;
  int checks = 0;

  v_multaddsub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .add_sub   (add_sub),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res       (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c, input logic as);
    a_in[i*WIDTH +: WIDTH] = a[WIDTH-1:0];
    b_in[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
    c_in[i*WIDTH +: WIDTH] = c[WIDTH-1:0];
    add_sub[i]             = as;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; c_in = '0; add_sub = '0;
    #12;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    checks++; if (res !== 16'h0000) begin errors++; $display("FAIL reset_res: got %h want 0000", res); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", res_id); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
  endtask

  // Issue one request from an idle pipeline and follow it to the output
  task automatic run_one(input string name, input int idx, input int a, input int b,
                         input int c, input logic as, input logic [15:0] exp_res);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << idx;
    set_op(idx, a, b, c, as);
    req = exp_gnt;
    tick();
    checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL %s_gnt: got %b want %b", name, gnt, exp_gnt); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || res_valid !== 1'b0) begin
      errors++; $display("FAIL %s_gap: gnt=%b valid=%b want 0000/0", name, gnt, res_valid);
    end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, res_valid); end
    checks++; if (res !== exp_res) begin errors++; $display("FAIL %s_res: got %h want %h", name, res, exp_res); end
    checks++; if (res_id !== 2'(idx)) begin errors++; $display("FAIL %s_id: got %0d want %0d", name, res_id, idx); end
    tick();
    checks++; if (res_valid !== 1'b0 || res !== exp_res) begin
      errors++; $display("FAIL %s_hold: valid=%b res=%h want 0/%h", name, res_valid, res, exp_res);
    end
  endtask

  task automatic test_single();
    run_one("single", 0, 200, 100, 5, 1'b1, 16'h4E25);
  endtask

  task automatic test_sub_wrap();
    run_one("subwrap", 2, 200, 100, 5, 1'b0, 16'hB1E5);
  endtask

  task automatic test_overflow();
    run_one("addovf", 3, 255, 255, 255, 1'b1, 16'hFF00);
    run_one("subovf", 1, 255, 255, 0, 1'b0, 16'h01FF);
  endtask

  // All four held from reset release; each drops req in its grant cycle
  task automatic test_back_to_back();
    logic [15:0] exp_r [4];
    exp_r[0] = 16'd22;    // 10 + 3*4
    exp_r[1] = 16'hFFCE;  // 50 - 100 mod 2^16
    exp_r[2] = 16'd257;   // 1 + 16*16
    exp_r[3] = 16'd77;    // 77 - 0
    @(negedge clk) rst_n = 1'b0;
    set_op(0, 3, 4, 10, 1'b1);
    set_op(1, 10, 10, 50, 1'b0);
    set_op(2, 16, 16, 1, 1'b1);
    set_op(3, 0, 99, 77, 1'b0);
    req = 4'b1111;
    @(negedge clk) rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n <= 4) begin
        checks++; if (gnt !== (4'b0001 << (n-1))) begin
          errors++; $display("FAIL b2b_gnt%0d: got %b want %b", n, gnt, 4'b0001 << (n-1));
        end
        req[n-1] = 1'b0;
      end
      if (n >= 3 && n <= 6) begin
        checks++; if (res_valid !== 1'b1 || res_id !== 2'(n-3) || res !== exp_r[n-3]) begin
          errors++; $display("FAIL b2b_res%0d: valid=%b id=%0d res=%h want 1/%0d/%h",
                             n, res_valid, res_id, res, n-3, exp_r[n-3]);
        end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_novalid%0d: got %b want 0", n, res_valid); end
      end
    end
  endtask

  // Single client holding req: grant every other cycle
  task automatic test_single_hold();
    logic       exp_g;
    logic       exp_v;
    set_op(1, 7, 9, 100, 1'b1);  // 100 + 63 = 163
    req = 4'b0010;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_g = (n == 1 || n == 3 || n == 5);
      exp_v = (n == 3 || n == 5 || n == 7);
      checks++; if (gnt !== {2'b00, exp_g, 1'b0}) begin
        errors++; $display("FAIL hold_gnt%0d: got %b want %b", n, gnt, {2'b00, exp_g, 1'b0});
      end
      checks++; if (res_valid !== exp_v) begin errors++; $display("FAIL hold_valid%0d: got %b want %b", n, res_valid, exp_v); end
      if (exp_v) begin
        checks++; if (res !== 16'd163 || res_id !== 2'd1) begin
          errors++; $display("FAIL hold_res%0d: res=%0d id=%0d want 163/1", n, res, res_id);
        end
      end
      if (n == 6) req = 4'b0000;
    end
  endtask

  // Async reset while two ops are in flight; nothing may emerge and ptr restarts at 0
  task automatic test_reset_midflight();
    set_op(0, 2, 3, 4, 1'b1);
    set_op(1, 5, 5, 5, 1'b1);   // 5 + 25 = 30
    set_op(3, 1, 1, 1, 1'b1);   // 1 + 1 = 2
    req = 4'b0011;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt0: got %b want 0001", gnt); end
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt1: got %b want 0010", gnt); end
    req = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || res_valid !== 1'b0 || res !== 16'h0000 || res_id !== 2'd0) begin
      errors++; $display("FAIL mid_async: gnt=%b valid=%b res=%h id=%0d want all zero", gnt, res_valid, res, res_id);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_flush%0d: got %b want 0", n, res_valid); end
    end
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_ptr: got %b want 0010", gnt); end
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL mid_next: got %b want 1000", gnt); end
    req = 4'b0000;
    tick();
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res !== 16'd30) begin
      errors++; $display("FAIL mid_res1: valid=%b id=%0d res=%0d want 1/1/30", res_valid, res_id, res);
    end
    tick();
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res !== 16'd2) begin
      errors++; $display("FAIL mid_res3: valid=%b id=%0d res=%0d want 1/3/2", res_valid, res_id, res);
    end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_end: got %b want 0", res_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sub_wrap();
    test_overflow();
    test_back_to_back();
    test_single_hold();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
